note_seq_ctrl: RTL

//  Record/playback sequencer for the piano's 8-slot note memory. It records key codes into
//  the note RAM in record mode and replays them at a fixed tempo in play mode.

---
 rtl/note_seq_if.sv | 25 ++
 rtl/note_seq_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/note_seq_if.sv
// note_seq_if: keypad/control inputs and tone-generator outputs of the note sequencer.
interface note_seq_if #(
    parameter int ADDR_W = 3,
    parameter int NOTE_W = 4
);
    logic              mode;
    logic              start;
    logic              stop;
    logic              key_valid;
    logic [NOTE_W-1:0] key_code;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              rec_done;
    logic              play_done;
    modport master (
        output mode, start, stop, key_valid, key_code,
        input  note_out, note_valid, addr, busy, rec_done, play_done
    );
    modport slave (
        input  mode, start, stop, key_valid, key_code,
        output note_out, note_valid, addr, busy, rec_done, play_done
    );
endinterface

// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: record/playback sequencer owning the note RAM, slot pointer, length and tempo divider.
module note_seq_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int NOTE_W    = 4,
    parameter int TEMPO_DIV = 16
) (
    input logic       clock,
    input logic       reset,
    note_seq_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(TEMPO_DIV);
    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;
    state_t            state, state_n;
    logic              start_q, key_q, start_e, key_e;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [ADDR_W:0]   len, len_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [NOTE_W-1:0] note_r, note_n;
    logic              nv_r, nv_n, busy_r, rd_r, rd_n, pd_r, pd_n, wr;
    logic [NOTE_W-1:0] mem [DEPTH];
    assign start_e        = bus.start & ~start_q;
    assign key_e          = bus.key_valid & ~key_q;
    assign bus.note_out   = note_r;
    assign bus.note_valid = nv_r;
    assign bus.addr       = addr_r;
    assign bus.busy       = busy_r;
    assign bus.rec_done   = rd_r;
    assign bus.play_done  = pd_r;
    always_comb begin
        state_n = state;
        addr_n  = addr_r;
        len_n   = len;
        cnt_n   = cnt;
        note_n  = note_r;
        nv_n    = nv_r;
        rd_n    = 1'b0;
        pd_n    = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE: if (!bus.stop && start_e) begin
                if (bus.mode) begin
                    state_n = REC;
                    addr_n  = '0;
                    len_n   = '0;
                end else if (len != '0) begin
                    // first note is presented together with the entry into PLAY
                    state_n = PLAY;
                    addr_n  = '0;
                    cnt_n   = '0;
                    note_n  = mem[0];
                    nv_n    = 1'b1;
                end else begin
                    pd_n = 1'b1;
                end
            end
            REC: if (bus.stop) begin
                state_n = IDLE;
                rd_n    = 1'b1;
            end else if (key_e) begin
                wr    = 1'b1;
                len_n = {1'b0, addr_r} + (ADDR_W+1)'(1);
                if (addr_r == ADDR_W'(DEPTH-1)) begin
                    state_n = IDLE;
                    rd_n    = 1'b1;
                end else begin
                    addr_n = addr_r + ADDR_W'(1);
                end
            end
            PLAY: if (bus.stop) begin
                state_n = IDLE;
                nv_n    = 1'b0;
                note_n  = '0;
            end else if (cnt == CNT_W'(TEMPO_DIV-1)) begin
                if ({1'b0, addr_r} == len - (ADDR_W+1)'(1)) begin
                    state_n = IDLE;
                    pd_n    = 1'b1;
                    nv_n    = 1'b0;
                    note_n  = '0;
                end else begin
                    addr_n = addr_r + ADDR_W'(1);
                    cnt_n  = '0;
                    note_n = mem[addr_r + ADDR_W'(1)];
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            key_q   <= 1'b0;
            addr_r  <= '0;
            len     <= '0;
            cnt     <= '0;
            note_r  <= '0;
            nv_r    <= 1'b0;
            busy_r  <= 1'b0;
            rd_r    <= 1'b0;
            pd_r    <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= bus.start;
            key_q   <= bus.key_valid;
            addr_r  <= addr_n;
            len     <= len_n;
            cnt     <= cnt_n;
            note_r  <= note_n;
            nv_r    <= nv_n;
            busy_r  <= state_n != IDLE;
            rd_r    <= rd_n;
            pd_r    <= pd_n;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[addr_r] <= bus.key_code;
        end
    end
endmodule
